// File: rtl/dcache_pkg.sv
// Shared types for the data cache control path.
// State encoding and timer sizing helpers.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    ALLOCATE,
    FLUSH_SCAN,
    FLUSH_WB,
    FLUSH_DONE
  } dcache_state_t;

  function automatic int timer_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ACK_TIMEOUT_DEF = 64;
  localparam int TIMER_W = timer_w(ACK_TIMEOUT_DEF);

  function automatic logic is_wait(dcache_state_t s);
    return (s == WRITEBACK) || (s == ALLOCATE) || (s == FLUSH_WB);
  endfunction

endpackage

// File: rtl/dcache_controller.sv
// Direct-mapped dcache control FSM: hit/miss decode,
// write-back/allocate bus sequencing and full-cache flush.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int SIZE        = 256,
  parameter int INDEX_BITS  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  cache_hit_i,
  input  logic                  cache_evict_req_i,
  input  logic                  cache_flush_i,
  input  logic [SIZE-1:0]       dirty_vector,
  input  logic                  mem2dcache_ack_i,
  output logic                  cache_line_wr_o,
  output logic                  cache_wrb_req_o,
  output logic                  cache_line_clean_o,
  output logic [INDEX_BITS-1:0] evict_index_o,
  output logic                  dcache2mem_req_o,
  output logic                  dcache2mem_wr_o,
  output logic                  dcache2lsu_ack_o,
  output logic                  flush_done_o,
  output logic                  timeout_err_o
);

  localparam int TW = timer_w(ACK_TIMEOUT);
  localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(SIZE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  dcache_state_t state;
  dcache_state_t state_n;

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] idx_n;
  logic [TW-1:0]         timer;
  logic                  flush_pend;
  logic                  lsu_ack_q;
  logic                  err_q;
  logic                  timeout;
  logic                  advance;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Line index, ack timer, pending flush, LSU ack and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      lsu_ack_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx <= idx_n;
      if (state_n != state) begin
        timer <= '0;
      end else if (is_wait(state)) begin
        timer <= timer + 1'b1;
      end
      if (state == IDLE && (cache_flush_i || flush_pend)) begin
        flush_pend <= 1'b0;
      end else if (cache_flush_i && state != IDLE) begin
        flush_pend <= 1'b1;
      end
      lsu_ack_q <= (state == LOOKUP) && cache_hit_i;
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next state and next flush index
  always_comb begin
    state_n = state;
    idx_n   = idx;
    timeout = 1'b0;
    advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (cache_flush_i || flush_pend) begin
          state_n = FLUSH_SCAN;
        end else if ((read_en || write_en) && !lsu_ack_q) begin
          // LSU still holds its request during the ack cycle
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cache_hit_i) begin
          state_n = IDLE;
        end else if (cache_evict_req_i) begin
          state_n = WRITEBACK;
        end else begin
          state_n = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem2dcache_ack_i) begin
          state_n = ALLOCATE;
        end else if (timer == T_LAST) begin
          timeout = 1'b1;
        end
      end
      ALLOCATE: begin
        if (mem2dcache_ack_i) begin
          state_n = LOOKUP;
        end else if (timer == T_LAST) begin
          timeout = 1'b1;
        end
      end
      FLUSH_SCAN: begin
        if (dirty_vector[idx]) begin
          state_n = FLUSH_WB;
        end else begin
          advance = 1'b1;
        end
      end
      FLUSH_WB: begin
        if (mem2dcache_ack_i) begin
          advance = 1'b1;
        end else if (timer == T_LAST) begin
          timeout = 1'b1;
        end
      end
      FLUSH_DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (advance) begin
      if (idx == LAST) begin
        state_n = FLUSH_DONE;
        idx_n   = '0;
      end else begin
        state_n = FLUSH_SCAN;
        idx_n   = idx + 1'b1;
      end
    end
    if (timeout) begin
      // Aborted flush restarts from line 0 next time
      state_n = IDLE;
      idx_n   = '0;
    end
  end

  // Moore bus/flush outputs plus ack-qualified datapath pulses
  always_comb begin
    cache_line_wr_o    = 1'b0;
    cache_wrb_req_o    = 1'b0;
    cache_line_clean_o = 1'b0;
    dcache2mem_req_o   = 1'b0;
    dcache2mem_wr_o    = 1'b0;
    flush_done_o       = 1'b0;
    unique case (1'b1)
      (state == WRITEBACK),
      (state == FLUSH_WB): begin
        dcache2mem_req_o   = 1'b1;
        dcache2mem_wr_o    = 1'b1;
        cache_wrb_req_o    = 1'b1;
        cache_line_clean_o = mem2dcache_ack_i;
      end
      (state == ALLOCATE): begin
        dcache2mem_req_o = 1'b1;
        cache_line_wr_o  = mem2dcache_ack_i;
      end
      (state == FLUSH_DONE): begin
        flush_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign evict_index_o    = idx;
  assign dcache2lsu_ack_o = lsu_ack_q;
  assign timeout_err_o    = err_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller with a
// behavioural LSU, memory and datapath model.
module tb_dcache_controller;

  localparam int SIZE = 4;
  localparam int IB   = 2;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            read_en = 1'b0;
  logic            write_en = 1'b0;
  logic            cache_hit_i = 1'b0;
  logic            cache_evict_req_i = 1'b0;
  logic            cache_flush_i = 1'b0;
  logic [SIZE-1:0] dirty_vector = '0;
  logic            mem2dcache_ack_i = 1'b0;
  logic            cache_line_wr_o;
  logic            cache_wrb_req_o;
  logic            cache_line_clean_o;
  logic [IB-1:0]   evict_index_o;
  logic            dcache2mem_req_o;
  logic            dcache2mem_wr_o;
  logic            dcache2lsu_ack_o;
  logic            flush_done_o;
  logic            timeout_err_o;

  always #5 clk = ~clk;

  dcache_controller #(
    .SIZE(SIZE),
    .INDEX_BITS(IB),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_en(read_en),
    .write_en(write_en),
    .cache_hit_i(cache_hit_i),
    .cache_evict_req_i(cache_evict_req_i),
    .cache_flush_i(cache_flush_i),
    .dirty_vector(dirty_vector),
    .mem2dcache_ack_i(mem2dcache_ack_i),
    .cache_line_wr_o(cache_line_wr_o),
    .cache_wrb_req_o(cache_wrb_req_o),
    .cache_line_clean_o(cache_line_clean_o),
    .evict_index_o(evict_index_o),
    .dcache2mem_req_o(dcache2mem_req_o),
    .dcache2mem_wr_o(dcache2mem_wr_o),
    .dcache2lsu_ack_o(dcache2lsu_ack_o),
    .flush_done_o(flush_done_o),
    .timeout_err_o(timeout_err_o)
  );

  int checks = 0;
  int failures = 0;

  int lat_q[$];
  bit mem_en = 1'b1;
  int mcnt = 0;
  int cur_lat = 1;
  bit present = 1'b0;
  bit vdirty = 1'b0;
  logic [SIZE-1:0] dv_model = '0;
  logic [SIZE-1:0] wb_mask;

  int cyc, n_req, n_wr, n_rise, n_acks, n_lw, n_cl, n_done, n_lack;
  int first_lack, first_done, first_err, first_lw;
  bit prev_req;

  task automatic clr_stats();
    cyc = 0; n_req = 0; n_wr = 0; n_rise = 0; n_acks = 0;
    n_lw = 0; n_cl = 0; n_done = 0; n_lack = 0;
    first_lack = -1; first_done = -1; first_err = -1; first_lw = -1;
    prev_req = 1'b0; wb_mask = '0; mcnt = 0;
  endtask

  function automatic logic [9:0] outs();
    return {cache_line_wr_o, cache_wrb_req_o, cache_line_clean_o,
            evict_index_o, dcache2mem_req_o, dcache2mem_wr_o,
            dcache2lsu_ack_o, flush_done_o, timeout_err_o};
  endfunction

  // one clock: observe, answer as memory, update datapath model
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (dcache2mem_req_o) begin
      n_req++;
      if (!prev_req) n_rise++;
    end
    if (dcache2mem_wr_o) n_wr++;
    prev_req = dcache2mem_req_o;
    if (dcache2lsu_ack_o) begin
      n_lack++;
      if (first_lack < 0) first_lack = cyc;
      read_en = 1'b0;
      write_en = 1'b0;
    end
    if (flush_done_o) begin
      n_done++;
      if (first_done < 0) first_done = cyc;
    end
    if (timeout_err_o && first_err < 0) first_err = cyc;
    mem2dcache_ack_i = 1'b0;
    if (dcache2mem_req_o) begin
      if (mcnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      mcnt++;
      if (mem_en && mcnt >= cur_lat) begin
        mem2dcache_ack_i = 1'b1;
        mcnt = 0;
        n_acks++;
        if (dcache2mem_wr_o) wb_mask[evict_index_o] = 1'b1;
      end
    end else begin
      mcnt = 0;
    end
    #1;
    if (cache_line_wr_o) begin
      n_lw++;
      if (first_lw < 0) first_lw = cyc;
      present = 1'b1;
    end
    if (cache_line_clean_o) begin
      n_cl++;
      vdirty = 1'b0;
      dv_model[evict_index_o] = 1'b0;
    end
    cache_hit_i = present;
    cache_evict_req_i = vdirty && !present;
    dirty_vector = dv_model;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read_en = 1'b0; write_en = 1'b0; cache_flush_i = 1'b0;
    present = 1'b0; vdirty = 1'b0; dv_model = '0;
    lat_q.delete(); mem_en = 1'b1;
    clr_stats();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic do_cpu(bit wr, bit hit, bit dirty, int lwb, int lf);
    int exp_ack, exp_lw;
    clr_stats();
    lat_q.delete();
    if (!hit) begin
      if (dirty) lat_q.push_back(lwb);
      lat_q.push_back(lf);
    end
    present = hit; vdirty = dirty;
    cache_hit_i = hit; cache_evict_req_i = dirty && !hit;
    mem_en = 1'b1;
    if (wr) write_en = 1'b1;
    else read_en = 1'b1;
    exp_ack = hit ? 2 : 3 + (dirty ? lwb : 0) + lf;
    exp_lw  = hit ? -1 : 1 + (dirty ? lwb : 0) + lf;
    while (n_lack == 0 && cyc < 200) cycle();
    repeat (3) cycle();
    checks++; if (first_lack !== exp_ack) begin failures++;
      $display("FAIL cpu_ack_cycle got=%0d exp=%0d hit=%0d dirty=%0d", first_lack, exp_ack, hit, dirty); end
    checks++; if (n_lack !== 1) begin failures++;
      $display("FAIL cpu_ack_count got=%0d exp=1", n_lack); end
    checks++; if (n_req !== (hit ? 0 : (dirty ? lwb : 0) + lf)) begin failures++;
      $display("FAIL cpu_req_cycles got=%0d exp=%0d", n_req, hit ? 0 : (dirty ? lwb : 0) + lf); end
    checks++; if (n_wr !== ((!hit && dirty) ? lwb : 0)) begin failures++;
      $display("FAIL cpu_wr_cycles got=%0d exp=%0d", n_wr, (!hit && dirty) ? lwb : 0); end
    checks++; if (n_rise !== (hit ? 0 : 1)) begin failures++;
      $display("FAIL cpu_req_continuous got=%0d exp=%0d", n_rise, hit ? 0 : 1); end
    checks++; if (n_acks !== (hit ? 0 : 1 + int'(dirty))) begin failures++;
      $display("FAIL cpu_mem_acks got=%0d exp=%0d", n_acks, hit ? 0 : 1 + int'(dirty)); end
    checks++; if (first_lw !== exp_lw || n_lw !== (hit ? 0 : 1)) begin failures++;
      $display("FAIL cpu_line_wr got=%0d@%0d exp=%0d@%0d", n_lw, first_lw, hit ? 0 : 1, exp_lw); end
    checks++; if (n_cl !== int'(!hit && dirty)) begin failures++;
      $display("FAIL cpu_clean got=%0d exp=%0d", n_cl, int'(!hit && dirty)); end
  endtask

  task automatic do_flush(logic [SIZE-1:0] dv);
    int sum;
    clr_stats();
    lat_q.delete();
    sum = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (dv[i]) begin
        int l;
        l = $urandom_range(1, 4);
        lat_q.push_back(l);
        sum += l;
      end
    end
    dv_model = dv; dirty_vector = dv; mem_en = 1'b1;
    cache_flush_i = 1'b1;
    cycle();
    cache_flush_i = 1'b0;
    while (n_done == 0 && cyc < 300) cycle();
    repeat (3) cycle();
    checks++; if (first_done !== 1 + SIZE + sum) begin failures++;
      $display("FAIL flush_done_cycle got=%0d exp=%0d dv=%b", first_done, 1 + SIZE + sum, dv); end
    checks++; if (n_done !== 1) begin failures++;
      $display("FAIL flush_done_count got=%0d exp=1", n_done); end
    checks++; if (wb_mask !== dv) begin failures++;
      $display("FAIL flush_wb_lines got=%b exp=%b", wb_mask, dv); end
    checks++; if (n_cl !== $countones(dv) || dv_model !== '0) begin failures++;
      $display("FAIL flush_clean got=%0d left=%b exp=%0d", n_cl, dv_model, $countones(dv)); end
    checks++; if (n_req !== sum || n_acks !== $countones(dv)) begin failures++;
      $display("FAIL flush_bus got=%0d/%0d exp=%0d/%0d", n_req, n_acks, sum, $countones(dv)); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (outs() !== 10'd0) begin failures++;
      $display("FAIL reset_outputs got=%b exp=0", outs()); end
  endtask

  task automatic test_hit();
    do_cpu(1'b0, 1'b1, 1'b0, 1, 1);
    do_cpu(1'b1, 1'b1, 1'b1, 1, 1);
  endtask

  task automatic test_clean_miss();
    do_cpu(1'b1, 1'b0, 1'b0, 1, 3);
    do_cpu(1'b0, 1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_dirty_miss();
    do_cpu(1'b0, 1'b0, 1'b1, 2, 3);
  endtask

  task automatic test_flush();
    do_flush(4'b1010);
    do_flush(4'b0000);
    do_flush(4'b1111);
  endtask

  task automatic test_random_cpu();
    for (int i = 0; i < 24; i++) begin
      do_cpu(1'($urandom % 2), ($urandom % 3) == 0, 1'($urandom % 2),
             $urandom_range(1, 5), $urandom_range(1, 5));
    end
  endtask

  task automatic test_random_flush();
    for (int i = 0; i < 5; i++) do_flush(SIZE'($urandom));
  endtask

  task automatic test_flush_during_alloc();
    clr_stats();
    lat_q.delete();
    lat_q.push_back(6);
    lat_q.push_back(2);
    present = 1'b0; vdirty = 1'b0;
    cache_hit_i = 1'b0; cache_evict_req_i = 1'b0;
    dv_model = 4'b0100; dirty_vector = 4'b0100;
    read_en = 1'b1;
    repeat (3) cycle();
    cache_flush_i = 1'b1;
    cycle();
    cache_flush_i = 1'b0;
    cycle();
    cache_flush_i = 1'b1;
    cycle();
    cache_flush_i = 1'b0;
    while (n_done == 0 && cyc < 300) cycle();
    repeat (4) cycle();
    checks++; if (first_lack !== 9) begin failures++;
      $display("FAIL pend_cpu_ack got=%0d exp=9", first_lack); end
    checks++; if (first_done !== 16) begin failures++;
      $display("FAIL pend_flush_done got=%0d exp=16", first_done); end
    checks++; if (n_done !== 1 || wb_mask !== 4'b0100) begin failures++;
      $display("FAIL pend_flush_once got=%0d mask=%b exp=1 mask=0100", n_done, wb_mask); end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    mem2dcache_ack_i = 1'b1;
    #1;
    checks++; if ({cache_line_wr_o, cache_line_clean_o} !== 2'b00) begin failures++;
      $display("FAIL stray_ack_pulse got=%b exp=00", {cache_line_wr_o, cache_line_clean_o}); end
    @(negedge clk);
    mem2dcache_ack_i = 1'b0;
    checks++; if (outs() !== 10'd0) begin failures++;
      $display("FAIL stray_ack_idle got=%b exp=0", outs()); end
  endtask

  task automatic test_timeout();
    do_reset();
    clr_stats();
    lat_q.delete();
    present = 1'b0; vdirty = 1'b0;
    cache_hit_i = 1'b0; cache_evict_req_i = 1'b0;
    mem_en = 1'b0;
    read_en = 1'b1;
    while (first_err < 0 && cyc < 40) cycle();
    read_en = 1'b0;
    repeat (3) cycle();
    mem_en = 1'b1;
    checks++; if (first_err !== 2 + TO) begin failures++;
      $display("FAIL timeout_cycle got=%0d exp=%0d", first_err, 2 + TO); end
    checks++; if (n_req !== TO || n_lack !== 0 || n_lw !== 0) begin failures++;
      $display("FAIL timeout_abort req=%0d lack=%0d lw=%0d exp=%0d/0/0", n_req, n_lack, n_lw, TO); end
    do_cpu(1'b0, 1'b1, 1'b0, 1, 1);
    checks++; if (timeout_err_o !== 1'b1) begin failures++;
      $display("FAIL timeout_sticky got=%b exp=1", timeout_err_o); end
  endtask

  task automatic test_reset_mid_wb();
    clr_stats();
    lat_q.delete();
    lat_q.push_back(20);
    lat_q.push_back(20);
    present = 1'b0; vdirty = 1'b1;
    cache_hit_i = 1'b0; cache_evict_req_i = 1'b1;
    read_en = 1'b1;
    repeat (4) cycle();
    checks++; if ({dcache2mem_req_o, dcache2mem_wr_o, cache_wrb_req_o} !== 3'b111) begin failures++;
      $display("FAIL mid_wb_active got=%b exp=111", {dcache2mem_req_o, dcache2mem_wr_o, cache_wrb_req_o}); end
    reset = 1'b1;
    read_en = 1'b0;
    present = 1'b0; vdirty = 1'b0;
    cycle();
    reset = 1'b0;
    lat_q.delete();
    checks++; if (outs() !== 10'd0) begin failures++;
      $display("FAIL mid_wb_reset got=%b exp=0", outs()); end
    clr_stats();
    repeat (3) cycle();
    checks++; if (n_req !== 0) begin failures++;
      $display("FAIL mid_wb_quiet got=%0d exp=0", n_req); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_flush();
    test_random_cpu();
    test_random_flush();
    test_flush_during_alloc();
    test_stray_ack();
    test_timeout();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
